counter_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit up/down counter among NUM_REQ requesters. Each requester asks for a single increment or decrement step. The block grants at most one requester per cycle and applies that step to the internal counter. It sits between requesting agents and any logic that consumes the shared count, and replaces direct wiring of several agents onto a counter's increment/decrement inputs.

---
 rtl/counter_arbiter_pkg.sv | 11 +
 rtl/counter_arbiter_rr_arbiter.sv | 35 +++
 rtl/counter_arbiter.sv | 85 ++++++++
 tb/tb_counter_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_arbiter_pkg.sv
// Shared constants for the round-robin shared-counter arbiter.
// Holds the direction encoding and the default sizing.
package counter_arbiter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 2;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin winner select.
// The search starts at i_ptr and wraps modulo NUM_REQ; the first active request wins.
module rr_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_valid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // i_ptr < NUM_REQ and i < NUM_REQ, so one subtraction brings the sum back into range
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        o_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up/down counter among NUM_REQ requesters.
// One step is applied per cycle; gnt, count and wrap are all direct register outputs.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dir,
  input  logic               clr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   count,
  output logic               wrap
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_ptr;
  logic [WIDTH-1:0]   r_count;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_wrap;

  logic [NUM_REQ-1:0] w_winner;
  logic               w_valid;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_ptr_next;
  logic               w_dir;
  logic [WIDTH:0]     w_step;

  // Returns {wrap, next_count} for a single modulo-2^WIDTH step.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] c, input logic up);
    if (up == DIR_UP) return {(c == '1), c + WIDTH'(1)};
    else              return {(c == '0), c - WIDTH'(1)};
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_idx = PTR_W'(i);
    end
    w_ptr_next = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + PTR_W'(1);
    w_dir      = dir[w_idx];
    w_step     = step_count(r_count, w_dir);
  end

  // Priority: reset_n > clr > grant; clr leaves the pointer alone so pending requests keep their turn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_gnt   <= '0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_gnt   <= '0;
      r_wrap  <= 1'b0;
    end else if (w_valid) begin
      r_ptr   <= w_ptr_next;
      r_count <= w_step[WIDTH-1:0];
      r_gnt   <= w_winner;
      r_wrap  <= w_step[WIDTH];
    end else begin
      r_gnt   <= '0;
      r_wrap  <= 1'b0;
    end
  end

  assign gnt   = r_gnt;
  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed testbench for counter_arbiter (NUM_REQ=4, WIDTH=2).
module tb_counter_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] dir;
  logic       clr;
  logic [3:0] gnt;
  logic [1:0] count;
  logic       wrap;

  int n_pass  = 0;
  int n_total = 0;

  counter_arbiter #(.NUM_REQ(4), .WIDTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .dir     (dir),
    .clr     (clr),
    .gnt     (gnt),
    .count   (count),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(negedge clk);
    req     = '0;
    dir     = '0;
    clr     = 1'b0;
    #2 reset_n = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (count !== 2'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++;
    if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap); else n_pass++;
    reset_n = 1'b1;
    req = 4'b1111;
    dir = 4'b1111;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++;
    if (count !== 2'd1) $display("FAIL reset_first_count: got %0d want 1", count); else n_pass++;
  endtask

  task automatic test_lone_up();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_wrp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reset_pulse();
    req = 4'b0010;
    dir = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (gnt !== 4'b0010) $display("FAIL lone_gnt[%0d]: got %b want 0010", i, gnt); else n_pass++;
      n_total++;
      if (count !== exp_cnt[i]) $display("FAIL lone_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); else n_pass++;
      n_total++;
      if (wrap !== exp_wrp[i]) $display("FAIL lone_wrap[%0d]: got %b want %b", i, wrap, exp_wrp[i]); else n_pass++;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_pulse();
    req = 4'b1111;
    dir = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (gnt !== exp_gnt[i]) $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); else n_pass++;
      n_total++;
      if (count !== exp_cnt[i]) $display("FAIL rot_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); else n_pass++;
    end
    req = 4'b0000;
    tick();
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL idle_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++;
    if (count !== 2'd1) $display("FAIL idle_count: got %0d want 1", count); else n_pass++;
    n_total++;
    if (wrap !== 1'b0) $display("FAIL idle_wrap: got %b want 0", wrap); else n_pass++;
  endtask

  task automatic test_mixed();
    logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    reset_pulse();
    req = 4'b0101;
    dir = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (gnt !== exp_gnt[i]) $display("FAIL mix_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); else n_pass++;
      n_total++;
      if (count !== exp_cnt[i]) $display("FAIL mix_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); else n_pass++;
    end
    req = 4'b0100;
    tick();
    n_total++;
    if (gnt !== 4'b0100) $display("FAIL down_wrap_gnt: got %b want 0100", gnt); else n_pass++;
    n_total++;
    if (count !== 2'd3) $display("FAIL down_wrap_count: got %0d want 3", count); else n_pass++;
    n_total++;
    if (wrap !== 1'b1) $display("FAIL down_wrap_flag: got %b want 1", wrap); else n_pass++;
  endtask

  task automatic test_dir_change();
    reset_pulse();
    req = 4'b0001;
    dir = 4'b0001;
    tick();
    dir = 4'b0000;
    tick();
    n_total++;
    if (count !== 2'd0) $display("FAIL dir_change_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (wrap !== 1'b0) $display("FAIL dir_change_wrap: got %b want 0", wrap); else n_pass++;
  endtask

  task automatic test_clear();
    reset_pulse();
    req = 4'b0001;
    dir = 4'b0001;
    tick();
    tick();
    n_total++;
    if (count !== 2'd2) $display("FAIL clr_setup_count: got %0d want 2", count); else n_pass++;
    req = 4'b1000;
    dir = 4'b1000;
    clr = 1'b1;
    tick();
    n_total++;
    if (count !== 2'd0) $display("FAIL clr_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL clr_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++;
    if (wrap !== 1'b0) $display("FAIL clr_wrap: got %b want 0", wrap); else n_pass++;
    clr = 1'b0;
    tick();
    n_total++;
    if (gnt !== 4'b1000) $display("FAIL clr_pending_gnt: got %b want 1000", gnt); else n_pass++;
    n_total++;
    if (count !== 2'd1) $display("FAIL clr_pending_count: got %0d want 1", count); else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    reset_pulse();
    req = 4'b1111;
    dir = 4'b1111;
    tick();
    tick();
    n_total++;
    if (count !== 2'd2) $display("FAIL mid_pre_count: got %0d want 2", count); else n_pass++;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (count !== 2'd0) $display("FAIL mid_async_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL mid_async_gnt: got %b want 0000", gnt); else n_pass++;
    tick();
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL mid_held_gnt: got %b want 0000", gnt); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL mid_restart_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++;
    if (count !== 2'd1) $display("FAIL mid_restart_count: got %0d want 1", count); else n_pass++;
    req = 4'b0000;
  endtask

  initial begin
    reset_n = 1'b1;
    req     = '0;
    dir     = '0;
    clr     = 1'b0;
    test_reset();
    test_lone_up();
    test_rotation();
    test_mixed();
    test_dir_change();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
